// File: rtl/pulse_gen_array.sv
// Array of NCH independent one-shot pulse generators with a shared completion counter.
// Define PULSE_GEN_RETRIGGER_EN to let a start during HIGH reload the pulse length instead of flagging err.
module pulse_gen_array #(
  parameter int NCH = 4,
  parameter int DW  = 4,
  parameter int CW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    start,
  input  logic [NCH*DW-1:0] delay,
  output logic [NCH-1:0]    pulse,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done,
  output logic              err,
  output logic [CW-1:0]     count
);

  typedef enum logic [1:0] {IDLE, HIGH, GUARD} state_t;

  state_t          state_q [NCH];
  state_t          state_d [NCH];
  logic [DW-1:0]   cnt_q   [NCH];
  logic [DW-1:0]   cnt_d   [NCH];
  logic [NCH-1:0]  viol;
  logic            err_q;
  logic [CW-1:0]   count_q;

  // A zero delay still produces a one-cycle pulse.
  function automatic logic [DW-1:0] load_len(input logic [DW-1:0] d);
    return (d == '0) ? DW'(1) : d;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [NCH-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int k = 0; k < NCH; k++) s = s + CW'(v[k]);
    return s;
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      viol[i]    = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (start[i]) begin
            state_d[i] = HIGH;
            cnt_d[i]   = load_len(delay[i*DW +: DW]);
          end
        end
        HIGH: begin
`ifdef PULSE_GEN_RETRIGGER_EN
          if (start[i]) begin
            cnt_d[i] = load_len(delay[i*DW +: DW]);
          end else if (cnt_q[i] == DW'(1)) begin
            state_d[i] = GUARD;
          end else begin
            cnt_d[i] = cnt_q[i] - DW'(1);
          end
`else
          viol[i] = start[i];
          if (cnt_q[i] == DW'(1)) state_d[i] = GUARD;
          else                    cnt_d[i]   = cnt_q[i] - DW'(1);
`endif
        end
        GUARD: begin
          // The edge closing the guard cycle may accept a new request; pulse stays low during guard.
          if (start[i]) begin
            state_d[i] = HIGH;
            cnt_d[i]   = load_len(delay[i*DW +: DW]);
          end else begin
            state_d[i] = IDLE;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      err_q   <= err_q | (|viol);
      count_q <= count_q + popcount(done);
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pulse[i] = (state_q[i] == HIGH);
      done[i]  = (state_q[i] == GUARD);
      busy[i]  = (state_q[i] != IDLE);
    end
  end

  assign err   = err_q;
  assign count = count_q;

endmodule

// File: tb/tb_pulse_gen_array.sv
// Bench for pulse_gen_array: directed scenarios plus random traffic against a timeline model.
module tb_pulse_gen_array;
  localparam int NCH = 4;
  localparam int DW  = 4;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    start = '0;
  logic [NCH*DW-1:0] delay = '0;
  logic [NCH-1:0]    pulse, busy, done;
  logic              err;
  logic [CW-1:0]     count;

  int tests = 0;
  int fails = 0;
  int ecount = 0;

  // Model: each channel remembers the edge its current pulse was accepted and its length.
  int            m_acc [NCH];
  int            m_len [NCH];
  logic          m_err;
  logic [CW-1:0] m_count;

  pulse_gen_array #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .delay(delay),
    .pulse(pulse), .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = -100;
      m_len[i] = 0;
    end
    m_err   = 1'b0;
    m_count = '0;
  endtask

  task automatic check_model();
    logic [NCH-1:0] ep, ed, eb;
    for (int i = 0; i < NCH; i++) begin
      ep[i] = (ecount >= m_acc[i]) && (ecount < m_acc[i] + m_len[i]);
      ed[i] = (ecount == m_acc[i] + m_len[i]);
      eb[i] = ep[i] | ed[i];
    end
    check("pulse", 32'(pulse), 32'(ep));
    check("done",  32'(done),  32'(ed));
    check("busy",  32'(busy),  32'(eb));
    check("err",   32'(err),   32'(m_err));
    check("count", 32'(count), 32'(m_count));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic tick(input logic [NCH-1:0] s, input logic [NCH*DW-1:0] dl);
    int d;
    logic hi, gd;
    start = s;
    delay = dl;
    @(posedge clk);
    ecount++;
    for (int i = 0; i < NCH; i++) begin
      d  = int'(dl[i*DW +: DW]);
      if (d == 0) d = 1;
      hi = (ecount >= m_acc[i] + 1) && (ecount <= m_acc[i] + m_len[i]);
      gd = (ecount == m_acc[i] + m_len[i] + 1);
      if (gd) m_count = m_count + 1'b1;
      if (s[i]) begin
        if (hi) begin
`ifdef PULSE_GEN_RETRIGGER_EN
          m_acc[i] = ecount;
          m_len[i] = d;
`else
          m_err = 1'b1;
`endif
        end else begin
          m_acc[i] = ecount;
          m_len[i] = d;
        end
      end
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pulse", 32'(pulse), 32'(0));
    check("rst_busy",  32'(busy),  32'(0));
    check("rst_done",  32'(done),  32'(0));
    check("rst_err",   32'(err),   32'(0));
    check("rst_count", 32'(count), 32'(0));
    start = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hc;
    logic [NCH-1:0] rs;
    logic [NCH*DW-1:0] rd;
    model_reset();

    // Reset state
    do_reset();

    // Channel 0, delay 3: pulse for three cycles, then done, count 1
    tick('0, '0);
    tick(4'b0001, 16'h0003);
    for (int k = 0; k < 5; k++) tick('0, 16'hFFFF);
    check("single_count", 32'(count), 32'(1));

    // Delay 0 behaves as a one-cycle pulse
    tick(4'b0010, 16'h0000);
    tick('0, '0);
    tick('0, '0);
    tick('0, '0);

    // Simultaneous completions wrap the counter: reach 254, then four more
    do_reset();
    for (int r = 0; r < 63; r++) begin
      tick(4'hF, 16'h0000);
      tick('0, '0);
      tick('0, '0);
    end
    tick(4'b0011, 16'h0000);
    tick('0, '0);
    tick('0, '0);
    check("preset_254", 32'(count), 32'(254));
    tick(4'hF, 16'h2222);
    for (int k = 0; k < 4; k++) tick('0, '0);
    check("wrap_count", 32'(count), 32'(2));

    // Start held high with delay 2: 1,1,0 repeating on channel 1
    do_reset();
    for (int k = 0; k < 12; k++) tick(4'b0010, 16'h0020);
    tick('0, '0);
    tick('0, '0);

    // Start during HIGH after two cycles on channel 2 (delay 5)
    do_reset();
    hc = 0;
    tick(4'b0100, 16'h0500);
    hc += int'(pulse[2]);
    tick('0, '0);
    hc += int'(pulse[2]);
    tick(4'b0100, 16'h0500);
    hc += int'(pulse[2]);
    for (int k = 0; k < 10; k++) begin
      tick('0, '0);
      hc += int'(pulse[2]);
    end
`ifdef PULSE_GEN_RETRIGGER_EN
    check("retrig_len", 32'(hc), 32'(7));
    check("retrig_err", 32'(err), 32'(0));
`else
    check("retrig_len", 32'(hc), 32'(5));
    check("retrig_err", 32'(err), 32'(1));
`endif

    // Random traffic, including delay changes while pulses are active
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NCH; i++) rs[i] = ($urandom_range(0, 3) == 0);
      rd = NCH*DW'($urandom);
      tick(rs, rd);
    end

    // Reset mid-pulse: pulse drops at once, no done, count and err cleared
    do_reset();
    tick(4'b0001, 16'h0009);
    tick('0, '0);
    tick('0, '0);
    check("pre_rst_pulse", 32'(pulse[0]), 32'(1));
    #2;
    do_reset();
    tick('0, '0);
    tick('0, '0);
    check("post_rst_count", 32'(count), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
